// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if -- pipeline hazard control bundle.
//
// Carries the decode/execute hazard information and interrupt request into the
// hazard controller, and carries the pipeline hold/flush/redirect controls back
// out to the pipeline.
//   master : pipeline side (drives *_i, observes *_o)
//   slave  : hazard controller (observes *_i, drives *_o)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  // decode-stage source registers (0 = unused)
  logic [4:0]  id_reg1_raddr_i;
  logic [4:0]  id_reg2_raddr_i;
  // execute-stage destination info
  logic        ex_reg_we_i;
  logic [4:0]  ex_reg_waddr_i;
  logic        ex_is_load_i;
  // execute-stage redirect and multi-cycle busy
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_busy_i;
  // interrupt request (level) and vector
  logic        int_req_i;
  logic [31:0] int_addr_i;
  // pipeline control
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        hold_id_ex_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        int_ack_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output id_reg1_raddr_i, id_reg2_raddr_i, ex_reg_we_i, ex_reg_waddr_i,
           ex_is_load_i, ex_jump_flag_i, ex_jump_addr_i, ex_busy_i,
           int_req_i, int_addr_i,
    input  hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, hold_id_ex_o,
           jump_flag_o, jump_addr_o, int_ack_o, stall_cnt_o
  );

  modport slave (
    input  id_reg1_raddr_i, id_reg2_raddr_i, ex_reg_we_i, ex_reg_waddr_i,
           ex_is_load_i, ex_jump_flag_i, ex_jump_addr_i, ex_busy_i,
           int_req_i, int_addr_i,
    output hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, hold_id_ex_o,
           jump_flag_o, jump_addr_o, int_ack_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard / redirect / interrupt controller.
//
// Ports:
//   clk   : core clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_ctrl_if.slave (hazard inputs in, pipeline controls out)
//
// Per-cycle event priority: jump > interrupt > busy > load-use.
// All pipeline controls are combinational from state and inputs; only the
// FSM state, the interrupt lockout flag and the stall counter are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    BUSY    = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        lockout_q, lockout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        run_like;
  logic        load_use;
  logic        int_take;

  logic        hold_pc, hold_if_id, hold_id_ex;
  logic        flush_if_id, flush_id_ex;
  logic        jump_flag, int_ack;
  logic [31:0] jump_addr;

  // BUSY with busy already dropped behaves as RUN in that same cycle, so a
  // pending interrupt or hazard is handled without losing a cycle.
  assign run_like = (state_q == RUN) || ((state_q == BUSY) && !bus.ex_busy_i);

  assign load_use = bus.ex_is_load_i && bus.ex_reg_we_i && (bus.ex_reg_waddr_i != 5'd0) &&
                    (((bus.id_reg1_raddr_i != 5'd0) && (bus.id_reg1_raddr_i == bus.ex_reg_waddr_i)) ||
                     ((bus.id_reg2_raddr_i != 5'd0) && (bus.id_reg2_raddr_i == bus.ex_reg_waddr_i)));

  // Lockout keeps a still-high level request from being acked again while the
  // FLUSH that follows its own ack is in progress.
  assign int_take = bus.int_req_i && !lockout_q && !bus.ex_busy_i &&
                    (run_like || (state_q == FLUSH));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = RUN;
    lockout_d   = lockout_q;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    flush_if_id = (state_q == FLUSH);
    flush_id_ex = 1'b0;
    jump_flag   = 1'b0;
    jump_addr   = 32'h0;
    int_ack     = 1'b0;

    if (bus.ex_jump_flag_i) begin
      jump_flag   = 1'b1;
      jump_addr   = bus.ex_jump_addr_i;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_d     = FLUSH;
    end else if (int_take) begin
      int_ack     = 1'b1;
      jump_flag   = 1'b1;
      jump_addr   = bus.int_addr_i;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      lockout_d   = 1'b1;
      state_d     = FLUSH;
    end else if (bus.ex_busy_i) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      hold_id_ex  = 1'b1;
      state_d     = BUSY;
    end else if (load_use && (run_like || (state_q == LDSTALL))) begin
      // Freeze PC and IF/ID, and inject a bubble into ID/EX.
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
      state_d     = LDSTALL;
    end

    // Interrupts are re-sampled only once the post-ack FLUSH has completed.
    if ((state_q == FLUSH) && (state_d != FLUSH)) begin
      lockout_d = 1'b0;
    end

    // A flushed register must not also be held.
    if (flush_if_id) hold_if_id = 1'b0;
    if (flush_id_ex) hold_id_ex = 1'b0;

    // Controls are quiet for the whole reset window, independent of inputs.
    if (!rst_n) begin
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_flag   = 1'b0;
      jump_addr   = 32'h0;
      int_ack     = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (hold_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      lockout_q   <= 1'b0;
      stall_cnt_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q     <= state_d;
      lockout_q   <= lockout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.hold_pc_o     = hold_pc;
  assign bus.hold_if_id_o  = hold_if_id;
  assign bus.hold_id_ex_o  = hold_id_ex;
  assign bus.flush_if_id_o = flush_if_id;
  assign bus.flush_id_ex_o = flush_id_ex;
  assign bus.jump_flag_o   = jump_flag;
  assign bus.jump_addr_o   = jump_addr;
  assign bus.int_ack_o     = int_ack;
  assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: id_reg1_raddr_i / id_reg2_raddr_i  in  5 each  decode-stage source register addresses (0 = unused).
REQ-004 SHALL have ports: ex_reg_we_i  in  1, ex_reg_waddr_i  in  5, ex_is_load_i  in  1  execute-stage destination info.
REQ-005 SHALL have ports: ex_jump_flag_i  in  1, ex_jump_addr_i  in  32  branch/jump redirect from execute.
REQ-006 SHALL have ports: ex_busy_i  in  1  multi-cycle mul/div in progress.
REQ-007 SHALL have ports: int_req_i  in  1 (level), int_addr_i  in  32  interrupt request and vector.
REQ-008 SHALL have ports: hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, hold_id_ex_o  out  1 each  pipeline control.
REQ-009 SHALL have ports: jump_flag_o  out  1, jump_addr_o  out  32  PC redirect; int_ack_o  out  1.
REQ-010 SHALL have ports: stall_cnt_o  out  32  saturating count of stalled cycles.

Function
REQ-011 SHALL implement FSM states RUN, LDSTALL, BUSY, FLUSH; state register only in clk domain.
REQ-012 Load-use hazard SHALL be: ex_is_load_i & ex_reg_we_i & ex_reg_waddr_i!=0 & waddr equals a nonzero id_reg1/2_raddr_i.
REQ-013 Event priority per cycle, highest first, SHALL be: jump > interrupt > busy > load-use.
REQ-014 Jump (any state): jump_flag_o=1, jump_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1 same cycle (combinational); next state FLUSH.
REQ-015 FLUSH SHALL last exactly 1 cycle asserting flush_if_id_o=1 only, then RUN; a new jump in FLUSH SHALL restart FLUSH.
REQ-016 Interrupt SHALL be taken only in RUN or FLUSH with no jump and ex_busy_i=0: int_ack_o=1 one cycle, jump_flag_o=1, jump_addr_o=int_addr_i, both flushes asserted, next state FLUSH.
REQ-017 int_ack_o SHALL never assert in consecutive cycles; after ack, int_req_i is re-sampled only from the cycle after FLUSH.
REQ-018 ex_busy_i=1 without jump: hold_pc_o=hold_if_id_o=hold_id_ex_o=1, state BUSY; leave to RUN the cycle ex_busy_i is sampled 0.
REQ-019 Load-use in RUN: hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1 (bubble), state LDSTALL for exactly 1 cycle then RUN.
REQ-020 LDSTALL SHALL assert no holds by itself (the load has left EX); a fresh hazard there SHALL be re-evaluated per REQ-012.
REQ-021 Flush SHALL dominate hold on the same register: flush_x asserted forces hold_x=0.
REQ-022 When jump_flag_o=0, jump_addr_o SHALL be 0.
REQ-023 stall_cnt_o SHALL increment by 1 on every cycle hold_pc_o=1 and saturate at 32'hFFFF_FFFF.
REQ-024 All control outputs SHALL be combinational from state and inputs; only state, interrupt-lockout flag and stall_cnt_o are registered.

Reset
REQ-025 rst_n=0 SHALL immediately force state RUN, stall_cnt_o=0, lockout flag cleared, and all outputs 0 given idle inputs.
REQ-026 Reset asserted mid-BUSY or mid-FLUSH SHALL abandon the operation; first cycle after release behaves as RUN.

Verification
REQ-027 Load-use: ex load to x5, id_reg1_raddr_i=5 -> one cycle hold_pc_o=1, flush_id_ex_o=1, stall_cnt_o 0->1, then RUN.
REQ-028 x0 case: ex load to x0, id_reg1_raddr_i=0 -> no hold, stall_cnt_o stays 0.
REQ-029 Jump+busy same cycle: ex_jump_flag_i=1, addr 0x100, ex_busy_i=1 -> jump_flag_o=1, jump_addr_o=0x100, no hold, next cycle flush_if_id_o only.
REQ-030 Interrupt during busy: int_req_i=1, ex_busy_i=1 for 3 cycles -> 3 hold cycles, int_ack_o=0; cycle after busy drops int_ack_o=1, jump_addr_o=int_addr_i.
REQ-031 Saturation: preload-equivalent via long busy or forced counter -> stall_cnt_o holds 0xFFFF_FFFF under further stalls.
REQ-032 Async reset during BUSY -> outputs 0 without clock edge; after release with idle inputs, state RUN, no holds.
